// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared types and constants for the I2C register controller.
package roversPackage;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  localparam int unsigned NUM_CFG  = 8;
  localparam int unsigned NUM_STAT = 8;

  localparam logic [3:0] CFG_BASE  = 4'h0;
  localparam logic [3:0] STAT_BASE = 4'h8;

  function automatic logic [7:0] cfg_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Byte-level link between an I2C slave PHY and the register controller.
interface i2c_reg_ctrl_if;

  logic        bus_start;
  logic        bus_rw;
  logic        bus_stop;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [63:0] status_in;
  logic [63:0] cfg_out;
  logic [7:0]  cfg_wr_stb;
  logic        timeout;

  modport slave (
    input  bus_start, bus_rw, bus_stop, rx_valid, rx_data, tx_req, status_in,
    output tx_data, tx_valid, cfg_out, cfg_wr_stb, timeout
  );

  modport master (
    output bus_start, bus_rw, bus_stop, rx_valid, rx_data, tx_req, status_in,
    input  tx_data, tx_valid, cfg_out, cfg_wr_stb, timeout
  );

endinterface

// File: rtl/i2c_reg_ctrl_watchdog.sv
// Saturating inactivity counter; o_expire pulses on the cycle the limit is reached.
module comms_watchdog #(
    parameter int unsigned LIMIT = 50_000_000
) (
    input  logic sclk,
    input  logic rst,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != CW'(LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = !i_clear && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C register-map controller: 8 R/W config bytes at 0x0-0x7, 8 status bytes at 0x8-0xF.
module i2c_reg_ctrl
    import roversPackage::*;
#(
    parameter int unsigned SYSCLK_FREQ = 100_000_000,
    parameter int unsigned TIMEOUT_MS  = 500
) (
    input  logic           sclk,
    input  logic           rst,
    i2c_reg_ctrl_if.slave  bus
);

    localparam int unsigned WD_LIMIT = SYSCLK_FREQ / 1000 * TIMEOUT_MS;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_ptr;
    logic [63:0] r_cfg;
    logic [7:0]  r_wr_stb;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_timeout;
    logic [7:0]  w_rd_byte;
    logic        w_expire;
    logic        w_activity;

    assign w_activity = bus.rx_valid | bus.tx_req;

    comms_watchdog #(.LIMIT(WD_LIMIT)) u_watchdog (
        .sclk     (sclk),
        .rst      (rst),
        .i_clear  (w_activity),
        .o_expire (w_expire)
    );

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // bus_start overrides bus_stop; a byte arriving with bus_stop is still consumed below.
    always_comb begin
        w_next = r_state;
        if (bus.bus_start) begin
            w_next = bus.bus_rw ? RD : PTR;
        end else if (bus.bus_stop) begin
            w_next = IDLE;
        end else if (r_state == PTR && bus.rx_valid) begin
            w_next = WR;
        end
    end

    always_comb begin
        if (r_ptr >= STAT_BASE) begin
            w_rd_byte = bus.status_in[{r_ptr[2:0], 3'b000} +: 8];
        end else begin
            w_rd_byte = r_cfg[{r_ptr[2:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_cfg      <= '0;
            r_wr_stb   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wr_stb   <= '0;
            r_tx_valid <= 1'b0;

            if (w_expire) begin
                r_timeout <= 1'b1;
                r_cfg     <= '0;
            end

            if (bus.rx_valid) begin
                case (r_state)
                    PTR: r_ptr <= bus.rx_data[3:0];
                    WR: begin
                        if (r_ptr < STAT_BASE) begin
                            r_cfg[{r_ptr[2:0], 3'b000} +: 8] <= bus.rx_data;
                            r_wr_stb  <= cfg_onehot(r_ptr[2:0]);
                            r_timeout <= 1'b0;
                        end
                        r_ptr <= r_ptr + 4'd1;
                    end
                    default: ;
                endcase
            end

            if (bus.tx_req && r_state == RD) begin
                r_tx_data  <= w_rd_byte;
                r_tx_valid <= 1'b1;
                r_ptr      <= r_ptr + 4'd1;
            end
        end
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.cfg_out    = r_cfg;
    assign bus.cfg_wr_stb = r_wr_stb;
    assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: expected tx bytes and write strobes are queued at drive time.
module tb_i2c_reg_ctrl;

    typedef struct {
        logic [7:0] v;
        int         c;
    } exp_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_tx[$];
    exp_t q_stb[$];

    i2c_reg_ctrl_if bus_if ();

    i2c_reg_ctrl #(
        .SYSCLK_FREQ (1_000_000),
        .TIMEOUT_MS  (1)
    ) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus_if)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic start(input logic rw);
        bus_if.bus_start = 1'b1;
        bus_if.bus_rw    = rw;
        tick();
        bus_if.bus_start = 1'b0;
        bus_if.bus_rw    = 1'b0;
    endtask

    task automatic stop();
        bus_if.bus_stop = 1'b1;
        tick();
        bus_if.bus_stop = 1'b0;
    endtask

    // stb: expected one-hot strobe the byte should produce (0 = none).
    task automatic send_rx(input logic [7:0] d, input logic [7:0] stb, input bit with_stop = 1'b0);
        exp_t e;
        if (stb != 8'h00) begin
            e.v = stb;
            e.c = cyc + 1;
            q_stb.push_back(e);
        end
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = d;
        bus_if.bus_stop = with_stop;
        tick();
        bus_if.rx_valid = 1'b0;
        bus_if.bus_stop = 1'b0;
    endtask

    task automatic tx_read(input logic [7:0] exp_byte, input bit expect_resp = 1'b1);
        exp_t e;
        if (expect_resp) begin
            e.v = exp_byte;
            e.c = cyc + 1;
            q_tx.push_back(e);
        end
        bus_if.tx_req = 1'b1;
        tick();
        bus_if.tx_req = 1'b0;
    endtask

    always @(negedge sclk) begin
        exp_t e;
        if (!rst) begin
            if (bus_if.tx_valid) begin
                chk("tx_expected", 64'(q_tx.size() != 0), 64'd1);
                if (q_tx.size() != 0) begin
                    e = q_tx.pop_front();
                    chk("tx_data", 64'(bus_if.tx_data), 64'(e.v));
                    chk("tx_latency", 64'(cyc), 64'(e.c));
                end
            end
            if (bus_if.cfg_wr_stb != 8'h00) begin
                chk("stb_expected", 64'(q_stb.size() != 0), 64'd1);
                if (q_stb.size() != 0) begin
                    e = q_stb.pop_front();
                    chk("cfg_wr_stb", 64'(bus_if.cfg_wr_stb), 64'(e.v));
                    chk("stb_latency", 64'(cyc), 64'(e.c));
                end
            end
        end
    end

    initial begin
        logic [7:0] rd_exp [8];
        bus_if.bus_start = 1'b0;
        bus_if.bus_rw    = 1'b0;
        bus_if.bus_stop  = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'h00;
        bus_if.tx_req    = 1'b0;
        bus_if.status_in = 64'h8877_6655_44C3_5A11;

        tick(2);
        rst = 1'b0;
        tick();
        chk("rst_cfg_out", bus_if.cfg_out, 64'h0);
        chk("rst_wr_stb", 64'(bus_if.cfg_wr_stb), 64'h0);
        chk("rst_tx_data", 64'(bus_if.tx_data), 64'h0);
        chk("rst_tx_valid", 64'(bus_if.tx_valid), 64'h0);
        chk("rst_timeout", 64'(bus_if.timeout), 64'h0);

        // Sequential writes from pointer 2; a fourth byte lands in cfg4 showing ptr=4.
        start(1'b0);
        send_rx(8'h02, 8'h00);
        send_rx(8'hAB, 8'h04);
        send_rx(8'hCD, 8'h08);
        tick();
        chk("wr_byte2", 64'(bus_if.cfg_out[23:16]), 64'hAB);
        chk("wr_byte3", 64'(bus_if.cfg_out[31:24]), 64'hCD);
        send_rx(8'h77, 8'h10);
        stop();
        chk("wr_ptr4", 64'(bus_if.cfg_out[39:32]), 64'h77);

        // Pointer 0xF: status-range byte discarded, then wrap to 0 and 1.
        start(1'b0);
        send_rx(8'hFF, 8'h00);
        send_rx(8'h11, 8'h00);
        send_rx(8'h22, 8'h01);
        send_rx(8'h33, 8'h02);
        stop();
        chk("wrap_cfg", bus_if.cfg_out, 64'h0000_0077_CDAB_3322);

        // Pointer write then repeated start into read; walk 0x9..0xF and wrap to cfg0.
        start(1'b0);
        send_rx(8'h09, 8'h00);
        start(1'b1);
        tx_read(8'h5A);
        bus_if.status_in[15:8] = 8'h00;
        tick(3);
        chk("tx_hold", 64'(bus_if.tx_data), 64'h5A);
        rd_exp = '{8'hC3, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) begin
            tx_read(rd_exp[i]);
            tick();
        end
        tx_read(rd_exp[6]);
        send_rx(8'h55, 8'h00);
        tx_read(rd_exp[7]);
        stop();
        tx_read(8'h00, 1'b0);

        // tx_req while writing is ignored and leaves ptr untouched.
        start(1'b0);
        send_rx(8'h00, 8'h00);
        tx_read(8'h00, 1'b0);
        send_rx(8'hE1, 8'h01);
        stop();
        chk("tx_in_wr_ptr", 64'(bus_if.cfg_out[7:0]), 64'hE1);

        // Data byte coincident with STOP is written; bytes in IDLE are dropped.
        start(1'b0);
        send_rx(8'h05, 8'h00);
        send_rx(8'h99, 8'h20, 1'b1);
        send_rx(8'h44, 8'h00);
        tick();
        chk("rx_stop_cfg", bus_if.cfg_out, 64'h0000_9977_CDAB_33E1);

        // Reset mid-write aborts; bytes after release are ignored.
        start(1'b0);
        send_rx(8'h06, 8'h00);
        send_rx(8'h12, 8'h40);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_cfg", bus_if.cfg_out, 64'h0);
        chk("mid_rst_tx_data", 64'(bus_if.tx_data), 64'h0);
        chk("mid_rst_timeout", 64'(bus_if.timeout), 64'h0);
        rst = 1'b0;
        send_rx(8'h34, 8'h00);
        tick();
        chk("post_rst_ignored", bus_if.cfg_out, 64'h0);

        // Watchdog: 1000 idle cycles after the last byte clears cfg and raises timeout.
        start(1'b0);
        send_rx(8'h00, 8'h00);
        send_rx(8'hA5, 8'h01);
        stop();
        tick(997);
        chk("wd_not_yet", 64'(bus_if.timeout), 64'h0);
        chk("wd_cfg_kept", bus_if.cfg_out, 64'h0000_0000_0000_00A5);
        tick(3);
        chk("wd_timeout", 64'(bus_if.timeout), 64'h1);
        chk("wd_cfg_clear", bus_if.cfg_out, 64'h0);
        start(1'b0);
        send_rx(8'h00, 8'h00);
        chk("wd_ptr_keeps", 64'(bus_if.timeout), 64'h1);
        send_rx(8'h5C, 8'h01);
        chk("wd_clear", 64'(bus_if.timeout), 64'h0);
        chk("wd_cfg0", 64'(bus_if.cfg_out[7:0]), 64'h5C);
        stop();

        tick(4);
        chk("tx_q_empty", 64'(q_tx.size()), 64'h0);
        chk("stb_q_empty", 64'(q_stb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
